uart_tx_fifo: RTL and testbench

Parametrised, buffered UART transmitter that succeeds the fixed 8N1 transmitter. Bytes are accepted through a valid/ready push port into an internal FIFO and serialised LSB-first. Configurable elements: data width, runtime bit period, one or two stop bits, and optional parity. Back-to-back frames carry no idle gap. It sits between the command/response logic and the board TX pin.

---
 rtl/uart_tx_fifo.sv | 199 +++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Buffered UART transmitter with a valid/ready push FIFO,
//               runtime bit period, 1/2 stop bits, optional parity
//               (enabled by defining UART_TX_PARITY_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DIV_W-1:0]                 baud_div,
  input  logic                             stop2,
`ifdef UART_TX_PARITY_EN
  input  logic                             parity_odd,
`endif
  input  logic [DATA_BITS-1:0]             s_data,
  input  logic                             s_valid,
  output logic                             s_ready,
  output logic                             tx,
  output logic                             busy,
  output logic                             frame_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count
);

  localparam int c_AW = $clog2(FIFO_DEPTH);
  localparam int c_CW = $clog2(FIFO_DEPTH+1);
  localparam int c_BW = $clog2(DATA_BITS);
  localparam logic [c_BW-1:0] c_LAST_BIT = c_BW'(DATA_BITS-1);
  localparam logic [c_CW-1:0] c_FULL     = c_CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_t;

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [c_AW-1:0]      r_wr_ptr, r_rd_ptr;
  logic [c_CW-1:0]      r_count;
  state_t               r_state, w_state_next;
  logic [DATA_BITS-1:0] r_shift;
  logic [c_BW-1:0]      r_bit_idx;
  logic [DIV_W-1:0]     r_baud_cnt, r_div;
  logic                 r_stop2, r_stop_idx;
  logic                 r_tx, r_frame_done;
  logic                 w_push, w_pop, w_bit_end, w_tx_next, w_done_next;
  logic [DATA_BITS-1:0] w_head;
`ifdef UART_TX_PARITY_EN
  logic                 r_par_bit;
`endif

  assign s_ready    = (r_count != c_FULL);
  assign w_push     = s_valid && s_ready;
  assign w_head     = r_mem[r_rd_ptr];
  assign tx         = r_tx;
  assign busy       = (r_state != ST_IDLE);
  assign frame_done = r_frame_done;
  assign fifo_count = r_count;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= s_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // tx is registered alongside the state so each level lines up with its state
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_tx_next    = r_tx;
    w_done_next  = 1'b0;
    w_bit_end    = (r_baud_cnt == r_div);
    case (r_state)
      ST_IDLE: begin
        w_tx_next = 1'b1;
        if (r_count != '0) begin
          w_pop        = 1'b1;
          w_state_next = ST_START;
          w_tx_next    = 1'b0;
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          w_state_next = ST_DATA;
          w_tx_next    = r_shift[0];
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          if (r_bit_idx == c_LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            w_state_next = ST_PARITY;
            w_tx_next    = r_par_bit;
`else
            w_state_next = ST_STOP;
            w_tx_next    = 1'b1;
`endif
          end else begin
            w_tx_next = r_shift[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (w_bit_end) begin
          w_state_next = ST_STOP;
          w_tx_next    = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (w_bit_end && (r_stop_idx == r_stop2)) begin
          w_done_next = 1'b1;
          if (r_count != '0) begin
            w_pop        = 1'b1;
            w_state_next = ST_START;
            w_tx_next    = 1'b0;
          end else begin
            w_state_next = ST_IDLE;
            w_tx_next    = 1'b1;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_tx_next    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_tx         <= 1'b1;
      r_frame_done <= 1'b0;
      r_shift      <= '0;
      r_bit_idx    <= '0;
      r_baud_cnt   <= '0;
      r_div        <= '0;
      r_stop2      <= 1'b0;
      r_stop_idx   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par_bit    <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_next;
      r_tx         <= w_tx_next;
      r_frame_done <= w_done_next;
      if (w_pop) begin
        // Frame settings are frozen here so mid-frame changes wait for the next frame
        r_shift    <= w_head;
        r_div      <= baud_div;
        r_stop2    <= stop2;
        r_baud_cnt <= '0;
        r_bit_idx  <= '0;
        r_stop_idx <= 1'b0;
`ifdef UART_TX_PARITY_EN
        r_par_bit  <= parity_odd ? ~^w_head : ^w_head;
`endif
      end else if (r_state != ST_IDLE) begin
        if (w_bit_end) begin
          r_baud_cnt <= '0;
          if (r_state == ST_DATA) begin
            r_shift   <= r_shift >> 1;
            r_bit_idx <= r_bit_idx + c_BW'(1);
          end
          if (r_state == ST_STOP) r_stop_idx <= 1'b1;
        end else begin
          r_baud_cnt <= r_baud_cnt + DIV_W'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Directed self-checking bench for uart_tx_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

`ifdef UART_TX_PARITY_EN
  localparam int c_PBITS = 1;
`else
  localparam int c_PBITS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] baud_div = 16'd3;
  logic        stop2 = 1'b0;
  logic        parity_odd = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_valid = 1'b0;
  logic        s_ready, tx, busy, frame_done;
  logic [2:0]  fifo_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(4), .DIV_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .baud_div   (baud_div),
    .stop2      (stop2),
`ifdef UART_TX_PARITY_EN
    .parity_odd (parity_odd),
`endif
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done),
    .fifo_count (fifo_count)
  );

  typedef struct packed {
    logic [7:0]  data;
    logic [15:0] div;
    logic        stop2;
    logic        par_odd;
    logic [8:0]  exp_sd;   // start + data levels, first transmitted in bit 0
    logic        exp_par;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic int frame_nb(input logic s2);
    return 10 + c_PBITS + int'(s2);
  endfunction

  function automatic logic [11:0] build_pat(input logic [7:0] d, input logic po);
    logic [11:0] p;
    p      = '1;
    p[0]   = 1'b0;
    p[8:1] = d;
`ifdef UART_TX_PARITY_EN
    p[9]   = po ? ~^d : ^d;
`endif
    return p;
  endfunction

  task automatic push_byte(input logic [7:0] d);
    int w;
    @(negedge clk);
    s_data  = d;
    s_valid = 1'b1;
    w = 0;
    while (!s_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) check("push_timeout", {31'd0, s_ready}, 32'd1);
    @(posedge clk);
    #1 s_valid = 1'b0;
  endtask

  // Samples one frame starting at the next falling edge
  task automatic check_stream(input logic [11:0] pat, input int nb, input int div, input string nm);
    for (int k = 0; k < nb; k++) begin
      for (int c = 0; c <= div; c++) begin
        @(negedge clk);
        check(nm, {31'd0, tx}, {31'd0, pat[k]});
        check({nm, "_busy"}, {31'd0, busy}, 32'd1);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] pat;
    int bad;

    vecs[0] = '{8'hA5, 16'd3, 1'b0, 1'b0, 9'b101001010, 1'b0};
    vecs[1] = '{8'h00, 16'd0, 1'b1, 1'b1, 9'b000000000, 1'b1};
    vecs[2] = '{8'hFF, 16'd1, 1'b0, 1'b1, 9'b111111110, 1'b1};
    vecs[3] = '{8'h3C, 16'd2, 1'b1, 1'b0, 9'b001111000, 1'b0};
    vecs[4] = '{8'h07, 16'd1, 1'b0, 1'b1, 9'b000001110, 1'b0};
    vecs[5] = '{8'h07, 16'd1, 1'b0, 1'b0, 9'b000001110, 1'b1};

    repeat (2) @(negedge clk);
    check("reset_tx",         {31'd0, tx},         32'd1);
    check("reset_busy",       {31'd0, busy},       32'd0);
    check("reset_frame_done", {31'd0, frame_done}, 32'd0);
    check("reset_count",      {29'd0, fifo_count}, 32'd0);
    check("reset_ready",      {31'd0, s_ready},    32'd1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      baud_div   = vecs[i].div;
      stop2      = vecs[i].stop2;
      parity_odd = vecs[i].par_odd;
      pat        = '1;
      pat[8:0]   = vecs[i].exp_sd;
`ifdef UART_TX_PARITY_EN
      pat[9]     = vecs[i].exp_par;
`endif
      push_byte(vecs[i].data);
      @(posedge clk);
      check_stream(pat, frame_nb(vecs[i].stop2), int'(vecs[i].div), "table_tx");
      @(negedge clk);
      check("table_done_pulse", {31'd0, frame_done}, 32'd1);
      check("table_busy_low",   {31'd0, busy},       32'd0);
      @(negedge clk);
      check("table_done_clear", {31'd0, frame_done}, 32'd0);
      check("table_tx_idle",    {31'd0, tx},         32'd1);
    end

    // Six pushes on consecutive cycles: fill, back-pressure, back-to-back frames
    baud_div   = 16'd0;
    stop2      = 1'b0;
    parity_odd = 1'b0;
    @(negedge clk);
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          int w;
          s_data  = 8'(i + 1);
          s_valid = 1'b1;
          w = 0;
          while (!s_ready && w < 100) begin
            @(negedge clk);
            w++;
          end
          if (w >= 100) check("b2b_push_timeout", {31'd0, s_ready}, 32'd1);
          @(posedge clk);
          @(negedge clk);
          if (i == 1) check("push_pop_count", {29'd0, fifo_count}, 32'd1);
          if (i == 4) begin
            check("full_count", {29'd0, fifo_count}, 32'd4);
            check("full_ready", {31'd0, s_ready},    32'd0);
          end
        end
        s_valid = 1'b0;
      end
      begin
        @(posedge clk);
        @(posedge clk);
        for (int i = 0; i < 6; i++)
          check_stream(build_pat(8'(i + 1), 1'b0), frame_nb(1'b0), 0, "b2b_tx");
        @(negedge clk);
        check("b2b_done_pulse", {31'd0, frame_done}, 32'd1);
        check("b2b_busy_low",   {31'd0, busy},       32'd0);
      end
    join
    repeat (3) @(negedge clk);

    // Divisor change while frame 1 is in flight
    baud_div = 16'd3;
    push_byte(8'h5A);
    push_byte(8'hC3);
    baud_div = 16'd7;
    check_stream(build_pat(8'h5A, 1'b0), frame_nb(1'b0), 3, "div_frame1");
    check_stream(build_pat(8'hC3, 1'b0), frame_nb(1'b0), 7, "div_frame2");
    @(negedge clk);
    check("div_done_pulse", {31'd0, frame_done}, 32'd1);
    check("div_busy_low",   {31'd0, busy},       32'd0);
    repeat (3) @(negedge clk);

    // Asynchronous reset during data bit 3 with two bytes still queued
    baud_div = 16'd3;
    push_byte(8'h55);
    push_byte(8'hAA);
    push_byte(8'h11);
    repeat (17) @(negedge clk);
    check("pre_rst_tx",    {31'd0, tx},         32'd0);
    check("pre_rst_count", {29'd0, fifo_count}, 32'd2);
    #1 rst = 1'b1;
    #1;
    check("rst_tx",    {31'd0, tx},         32'd1);
    check("rst_busy",  {31'd0, busy},       32'd0);
    check("rst_count", {29'd0, fifo_count}, 32'd0);
    check("rst_ready", {31'd0, s_ready},    32'd1);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (frame_done !== 1'b0 || tx !== 1'b1) bad++;
    end
    rst = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (frame_done !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("post_rst_quiet", bad, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
